// File: rtl/key_debounce.sv
// Multi-channel key conditioner: two-flop synchroniser, per-channel stability
// counter, debounced level outputs and registered one-cycle rise/fall strobes.
module key_debounce #(
  parameter int           N       = 2,
  parameter int           CNT_MAX = 240000,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_out,
  output logic [N-1:0] key_rise,
  output logic [N-1:0] key_fall
);

  localparam int          CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic [N-1:0]  r_sync1;
  logic [N-1:0]  r_sync2;
  logic [N-1:0]  r_key;
  logic [N-1:0]  r_rise;
  logic [N-1:0]  r_fall;
  logic [CW-1:0] r_cnt [N];

  // NOTE: every register here is sequential state, so it is written with <=;
  // a blocking = would let later statements see the new value in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
      r_key   <= RST_VAL;
      r_rise  <= '0;
      r_fall  <= '0;
      // NOTE: the counter array is small per-channel state, not a RAM, so it is
      // cleared in the loop; reset mid-count must discard all progress.
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (r_sync2[i] == r_key[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CNT_LAST) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else begin
          // Input held away from the debounced level for CNT_MAX cycles: accept it.
          r_key[i]  <= r_sync2[i];
          r_cnt[i]  <= '0;
          r_rise[i] <= r_sync2[i];
          r_fall[i] <= ~r_sync2[i];
        end
      end
    end
  end

  assign key_out  = r_key;
  assign key_rise = r_rise;
  assign key_fall = r_fall;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (N=2, CNT_MAX=8): reset, press/release timing,
// bounce rejection, exact threshold, simultaneous channels, reset mid-count.
module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] key_out;
  logic [1:0] key_rise;
  logic [1:0] key_fall;

  int checks = 0;
  int errors = 0;

  key_debounce #(.N(2), .CNT_MAX(8), .RST_VAL(2'b00)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_out  (key_out),
    .key_rise (key_rise),
    .key_fall (key_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle; inputs set afterwards land on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ko,
                           input logic [1:0] kr, input logic [1:0] kf);
    check({tag, " key_out"},  key_out,  ko);
    check({tag, " key_rise"}, key_rise, kr);
    check({tag, " key_fall"}, key_fall, kf);
  endtask

  initial begin
    logic [1:0] ko;
    logic [1:0] kr;
    logic [1:0] kf;

    // 1. Reset held 3 edges with inputs high, then release.
    rst    = 1'b1;
    key_in = 2'b11;
    for (int e = 0; e < 3; e++) begin
      tick();
      check_all($sformatf("t1 rst e%0d", e), 2'b00, 2'b00, 2'b00);
    end
    rst = 1'b0;
    // First released edge captures key_in (E0), so key_out updates 9 edges later.
    for (int e = 0; e < 12; e++) begin
      tick();
      ko = (e >= 9) ? 2'b11 : 2'b00;
      kr = (e == 9) ? 2'b11 : 2'b00;
      check_all($sformatf("t1 rel e%0d", e), ko, kr, 2'b00);
    end

    // Return to a zero state through reset; reset itself makes no strobe.
    rst    = 1'b1;
    key_in = 2'b00;
    tick();
    check_all("t1 rst2", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;

    // 2. Clean press on channel 0, then clean release.
    key_in = 2'b01;
    for (int e = 0; e < 12; e++) begin
      tick();
      ko = (e >= 9) ? 2'b01 : 2'b00;
      kr = (e == 9) ? 2'b01 : 2'b00;
      check_all($sformatf("t2 press e%0d", e), ko, kr, 2'b00);
    end
    key_in = 2'b00;
    for (int e = 0; e < 12; e++) begin
      tick();
      ko = (e >= 9) ? 2'b00 : 2'b01;
      kf = (e == 9) ? 2'b01 : 2'b00;
      check_all($sformatf("t2 rel e%0d", e), ko, 2'b00, kf);
    end

    // 3a. Bounce 1,0,1,0 with 3-cycle levels, then settle low.
    for (int e = 0; e < 24; e++) begin
      key_in = (e < 12) ? {1'b0, ~e[1]} : 2'b00;
      if (e < 12) key_in = ((e / 3) % 2 == 0) ? 2'b01 : 2'b00;
      tick();
      check_all($sformatf("t3 bounce e%0d", e), 2'b00, 2'b00, 2'b00);
    end
    // 3b. One level held 7 cycles: counter reaches CNT_MAX-1 but never commits.
    for (int e = 0; e < 20; e++) begin
      key_in = (e < 7) ? 2'b01 : 2'b00;
      tick();
      check_all($sformatf("t3 hold7 e%0d", e), 2'b00, 2'b00, 2'b00);
    end

    // 4. Channel 1 high for exactly 8 captured cycles: rises at E9, falls at E17.
    for (int e = 0; e < 22; e++) begin
      key_in = (e < 8) ? 2'b10 : 2'b00;
      tick();
      ko = (e >= 9 && e < 17) ? 2'b10 : 2'b00;
      kr = (e == 9)  ? 2'b10 : 2'b00;
      kf = (e == 17) ? 2'b10 : 2'b00;
      check_all($sformatf("t4 thresh e%0d", e), ko, kr, kf);
    end

    // 5. Both channels pressed together; channel 0 released 2 edges after the rise.
    for (int e = 0; e < 24; e++) begin
      key_in = (e < 11) ? 2'b11 : 2'b10;
      tick();
      ko = (e < 9) ? 2'b00 : ((e < 20) ? 2'b11 : 2'b10);
      kr = (e == 9)  ? 2'b11 : 2'b00;
      kf = (e == 20) ? 2'b01 : 2'b00;
      check_all($sformatf("t5 simul e%0d", e), ko, kr, kf);
    end

    rst    = 1'b1;
    key_in = 2'b00;
    tick();
    check_all("t5 rst", 2'b00, 2'b00, 2'b00);
    rst = 1'b0;

    // 6. Press channel 0, reset for one edge at count 5 (E7); restart from E8.
    for (int e = 0; e < 20; e++) begin
      key_in = 2'b01;
      rst    = (e == 7);
      tick();
      ko = (e >= 17) ? 2'b01 : 2'b00;
      kr = (e == 17) ? 2'b01 : 2'b00;
      check_all($sformatf("t6 midrst e%0d", e), ko, kr, 2'b00);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
